// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: framed host-command decoder sitting between the UART
// receiver and the SPI master / UART transmitter. Assembles W/Q/R/P frames,
// launches SPI register transfers, pulses the global reset, and returns one
// response byte per command. Byte and SPI timeouts turn into a '?' response.
module uart_cmd_parser #(
  parameter int BYTE_TIMEOUT_CLKS = 5000000,
  parameter int SPI_TIMEOUT_CLKS  = 50000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_spi_start,
  output logic [7:0] o_spi_upper,
  output logic [7:0] o_spi_lower,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rx_byte,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_reset_all,
  output logic       o_cmd_error,
  output logic       o_busy
);

  localparam int BW = (BYTE_TIMEOUT_CLKS > 2) ? $clog2(BYTE_TIMEOUT_CLKS) : 1;
  localparam int SW = (SPI_TIMEOUT_CLKS  > 2) ? $clog2(SPI_TIMEOUT_CLKS)  : 1;
  localparam logic [BW-1:0] BYTE_TC = BW'(BYTE_TIMEOUT_CLKS - 1);
  localparam logic [SW-1:0] SPI_TC  = SW'(SPI_TIMEOUT_CLKS - 1);

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_Q    = 8'h51;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] OP_P    = 8'h50;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_SPI_START,
    S_SPI_WAIT, S_RST_PULSE, S_TX_SEND, S_TX_WAIT
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_is_q, w_is_q_nxt;
  logic [7:0]      r_spi_upper, w_upper_nxt;
  logic [7:0]      r_spi_lower, w_lower_nxt;
  logic [7:0]      r_tx_byte, w_tx_byte_nxt;
  logic            r_spi_start, r_tx_dv, r_reset_all, r_cmd_error, r_busy;
  logic [BW-1:0]   r_byte_cnt;
  logic [SW-1:0]   r_spi_cnt;
  logic            w_fire, w_err, w_resp_go;
  logic [7:0]      w_resp;
  logic            w_byte_run, w_spi_run;

  // Next-state, response selection and strobe decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_is_q_nxt    = r_is_q;
    w_upper_nxt   = r_spi_upper;
    w_lower_nxt   = r_spi_lower;
    w_tx_byte_nxt = r_tx_byte;
    w_fire        = 1'b0;
    w_err         = 1'b0;
    w_resp_go     = 1'b0;
    w_resp        = RSP_OK;
    case (r_state)
      S_IDLE: begin
        if (i_rx_dv) begin
          case (i_rx_byte)
            OP_W:    begin w_state_nxt = S_GET_ADDR; w_is_q_nxt = 1'b0; end
            OP_Q:    begin w_state_nxt = S_GET_ADDR; w_is_q_nxt = 1'b1; end
            OP_R:    w_state_nxt = S_RST_PULSE;
            OP_P:    w_resp_go = 1'b1;
            default: begin w_resp_go = 1'b1; w_resp = RSP_ERR; w_err = 1'b1; end
          endcase
        end
      end
      S_GET_ADDR: begin
        if (i_rx_dv) begin
          w_upper_nxt = i_rx_byte;
          if (r_is_q) begin
            w_lower_nxt = 8'h00;
            w_state_nxt = S_SPI_START;
          end else begin
            w_state_nxt = S_GET_DATA;
          end
        end else if (r_byte_cnt == BYTE_TC) begin
          w_resp_go = 1'b1; w_resp = RSP_ERR; w_err = 1'b1;
        end
      end
      S_GET_DATA: begin
        if (i_rx_dv) begin
          w_lower_nxt = i_rx_byte;
          w_state_nxt = S_SPI_START;
        end else if (r_byte_cnt == BYTE_TC) begin
          w_resp_go = 1'b1; w_resp = RSP_ERR; w_err = 1'b1;
        end
      end
      S_SPI_START: begin
        w_err       = i_rx_dv;
        w_state_nxt = S_SPI_WAIT;
      end
      S_SPI_WAIT: begin
        w_err = i_rx_dv;
        if (i_spi_done) begin
          w_resp_go = 1'b1;
          w_resp    = r_is_q ? i_spi_rx_byte : RSP_OK;
        end else if (r_spi_cnt == SPI_TC) begin
          w_resp_go = 1'b1; w_resp = RSP_ERR; w_err = 1'b1;
        end
      end
      S_RST_PULSE: begin
        w_err     = i_rx_dv;
        w_resp_go = 1'b1;
      end
      S_TX_SEND: begin
        w_err = i_rx_dv;
        if (!i_tx_active) begin
          w_fire      = 1'b1;
          w_state_nxt = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        w_err = i_rx_dv;
        if (i_tx_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Entering the send phase: o_tx_dv is registered, so when the
    // transmitter is already idle the strobe is issued on the entry cycle
    // and the FSM lands directly in TX_WAIT.
    if (w_resp_go) begin
      w_tx_byte_nxt = w_resp;
      if (!i_tx_active) begin
        w_fire      = 1'b1;
        w_state_nxt = S_TX_WAIT;
      end else begin
        w_state_nxt = S_TX_SEND;
      end
    end
  end

  assign w_byte_run = ((r_state == S_GET_ADDR) || (r_state == S_GET_DATA)) &&
                      (w_state_nxt == r_state) && !i_rx_dv;
  assign w_spi_run  = (r_state == S_SPI_WAIT) && (w_state_nxt == S_SPI_WAIT);

  // State, latched frame fields and registered output strobes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_is_q      <= 1'b0;
      r_spi_upper <= 8'h00;
      r_spi_lower <= 8'h00;
      r_tx_byte   <= 8'h00;
      r_spi_start <= 1'b0;
      r_tx_dv     <= 1'b0;
      r_reset_all <= 1'b0;
      r_cmd_error <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_q      <= w_is_q_nxt;
      r_spi_upper <= w_upper_nxt;
      r_spi_lower <= w_lower_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_spi_start <= (w_state_nxt == S_SPI_START);
      r_tx_dv     <= w_fire;
      r_reset_all <= (w_state_nxt == S_RST_PULSE);
      r_cmd_error <= w_err;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Timeout counters: clear whenever the waiting phase is (re)started or
  // left, saturate at the terminal count.
  always_ff @(posedge i_clock) begin
    if (i_reset || !w_byte_run)     r_byte_cnt <= '0;
    else if (r_byte_cnt != BYTE_TC) r_byte_cnt <= r_byte_cnt + 1'b1;
    if (i_reset || !w_spi_run)      r_spi_cnt  <= '0;
    else if (r_spi_cnt != SPI_TC)   r_spi_cnt  <= r_spi_cnt + 1'b1;
  end

  assign o_spi_start = r_spi_start;
  assign o_spi_upper = r_spi_upper;
  assign o_spi_lower = r_spi_lower;
  assign o_tx_dv     = r_tx_dv;
  assign o_tx_byte   = r_tx_byte;
  assign o_reset_all = r_reset_all;
  assign o_cmd_error = r_cmd_error;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames; a cycle-indexed table of
// expected strobes (filled from the command timing rules) is compared
// against the DUT every cycle, plus literal checks at key points.
module tb_uart_cmd_parser;
  localparam int BTO = 100;
  localparam int STO = 50;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_dv = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic       i_spi_done = 1'b0;
  logic [7:0] i_spi_rx_byte = 8'h00;
  logic       i_tx_active = 1'b0;
  logic       i_tx_done = 1'b0;
  logic       o_spi_start, o_tx_dv, o_reset_all, o_cmd_error, o_busy;
  logic [7:0] o_spi_upper, o_spi_lower, o_tx_byte;

  uart_cmd_parser #(.BYTE_TIMEOUT_CLKS(BTO), .SPI_TIMEOUT_CLKS(STO)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_spi_start(o_spi_start), .o_spi_upper(o_spi_upper), .o_spi_lower(o_spi_lower),
    .i_spi_done(i_spi_done), .i_spi_rx_byte(i_spi_rx_byte),
    .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .i_tx_active(i_tx_active),
    .i_tx_done(i_tx_done), .o_reset_all(o_reset_all), .o_cmd_error(o_cmd_error),
    .o_busy(o_busy));

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;

  // Expected events keyed by cycle number.
  logic [15:0] exp_ss[int];   // spi_start with {upper,lower}
  logic [7:0]  exp_tx[int];   // tx_dv with byte
  bit          exp_rst[int];
  bit          exp_err[int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison against the expected-event table.
  always @(negedge i_clock) begin
    if (chk_en) begin
      chk("spi_start", {31'd0, o_spi_start}, {31'd0, exp_ss.exists(cyc) != 0});
      if (exp_ss.exists(cyc)) chk("spi_upper_lower", {16'd0, o_spi_upper, o_spi_lower}, {16'd0, exp_ss[cyc]});
      chk("tx_dv", {31'd0, o_tx_dv}, {31'd0, exp_tx.exists(cyc) != 0});
      if (exp_tx.exists(cyc)) chk("tx_byte", {24'd0, o_tx_byte}, {24'd0, exp_tx[cyc]});
      chk("reset_all", {31'd0, o_reset_all}, {31'd0, exp_rst.exists(cyc) != 0});
      chk("cmd_error", {31'd0, o_cmd_error}, {31'd0, exp_err.exists(cyc) != 0});
    end
  end

  task automatic step();
    @(posedge i_clock); #1;
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic send(input logic [7:0] b, output int c);
    c = cyc; i_rx_dv = 1'b1; i_rx_byte = b;
    step();
    i_rx_dv = 1'b0; i_rx_byte = 8'h00;
  endtask

  task automatic spi_done(input logic [7:0] rb, output int m);
    m = cyc; i_spi_done = 1'b1; i_spi_rx_byte = rb;
    step();
    i_spi_done = 1'b0; i_spi_rx_byte = 8'h00;
  endtask

  // Transmitter acknowledges one cycle after the expected o_tx_dv cycle t.
  task automatic tx_ack(input int t);
    until_cyc(t + 1);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, m, s;
    step(); step();
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_tx_byte", {24'd0, o_tx_byte}, 32'd0);
    chk("rst_upper", {24'd0, o_spi_upper}, 32'd0);
    chk("rst_lower", {24'd0, o_spi_lower}, 32'd0);
    i_reset = 1'b0;
    step();

    // W F8 00 -> SPI write, 'K'
    send(8'h57, c); send(8'hF8, c); send(8'h00, c);
    exp_ss[c + 1] = 16'hF800;
    chk("w_busy", {31'd0, o_busy}, 32'd1);
    step(); step(); step();
    chk("w_hold_upper", {24'd0, o_spi_upper}, 32'hF8);
    exp_tx[cyc + 1] = 8'h4B;
    spi_done(8'h77, m);
    tx_ack(m + 1);
    chk("w_resp_literal", {24'd0, o_tx_byte}, 32'h4B);
    chk("w_idle_busy", {31'd0, o_busy}, 32'd0);

    // Q 10 -> read returns A5
    send(8'h51, c); send(8'h10, c);
    exp_ss[c + 1] = 16'h1000;
    step(); step();
    exp_tx[cyc + 1] = 8'hA5;
    spi_done(8'hA5, m);
    tx_ack(m + 1);
    chk("q_resp_literal", {24'd0, o_tx_byte}, 32'hA5);

    // R -> reset pulse then 'K'
    exp_rst[cyc + 1] = 1'b1;
    exp_tx[cyc + 2]  = 8'h4B;
    send(8'h52, c);
    tx_ack(c + 2);

    // Unknown opcode 'Z' -> '?' with error
    exp_tx[cyc + 1]  = 8'h3F;
    exp_err[cyc + 1] = 1'b1;
    send(8'h5A, c);
    tx_ack(c + 1);
    chk("z_resp_literal", {24'd0, o_tx_byte}, 32'h3F);

    // W 20 then silence -> byte timeout
    send(8'h57, c); send(8'h20, c1);
    exp_tx[c1 + BTO + 1]  = 8'h3F;
    exp_err[c1 + BTO + 1] = 1'b1;
    tx_ack(c1 + BTO + 1);
    // P strobed on the first IDLE cycle after tx_done
    exp_tx[cyc + 1] = 8'h4B;
    send(8'h50, c);
    tx_ack(c + 1);

    // Address byte coincident with terminal count is accepted
    send(8'h57, c);
    until_cyc(c + BTO);
    send(8'h66, c1);
    send(8'h77, c);
    exp_ss[c + 1] = 16'h6677;
    step();
    exp_tx[cyc + 1] = 8'h4B;
    spi_done(8'h00, m);
    tx_ack(m + 1);

    // Q 01 with done withheld -> SPI timeout; stray byte dropped with error
    send(8'h51, c); send(8'h01, c1);
    s = c1 + 1;
    exp_ss[s] = 16'h0100;
    exp_err[s + 6] = 1'b1;
    exp_tx[s + STO + 1]  = 8'h3F;
    exp_err[s + STO + 1] = 1'b1;
    until_cyc(s + 5);
    send(8'h99, c);
    tx_ack(s + STO + 1);

    // P while transmitter busy for 20 cycles
    c1 = cyc;
    i_tx_active = 1'b1;
    exp_tx[c1 + 21] = 8'h4B;
    send(8'h50, c);
    until_cyc(c1 + 10);
    chk("p_wait_busy", {31'd0, o_busy}, 32'd1);
    chk("p_wait_no_dv", {31'd0, o_tx_dv}, 32'd0);
    until_cyc(c1 + 20);
    i_tx_active = 1'b0;
    tx_ack(c1 + 21);

    // Reset during SPI_WAIT aborts silently
    send(8'h57, c); send(8'h33, c); send(8'h44, c);
    exp_ss[c + 1] = 16'h3344;
    step(); step(); step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_upper", {24'd0, o_spi_upper}, 32'd0);
    chk("abort_lower", {24'd0, o_spi_lower}, 32'd0);
    chk("abort_tx_byte", {24'd0, o_tx_byte}, 32'd0);
    spi_done(8'h5A, m);
    step(); step(); step();
    exp_tx[cyc + 1] = 8'h4B;
    send(8'h50, c);
    tx_ack(c + 1);
    step(); step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
